scan_seq_2to4: RTL and testbench

//  Sequencer directly upstream of the 2-to-4 decoder: drives its 2-bit select (a) and enable (en).

---
 rtl/scan_seq_2to4_pkg.sv | 16 +
 rtl/scan_seq_2to4_rr_next_sel.sv | 38 +++
 rtl/scan_seq_2to4.sv | 143 ++++++++++++++
 tb/tb_scan_seq_2to4.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/scan_seq_2to4_pkg.sv
// Shared definitions for the 2-to-4 decoder scan sequencer.
//   NCH     : number of decoder channels scanned
//   SEL_W   : width of the decoder select
//   state_t : sequencer FSM states
package scan_seq_2to4_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

endpackage

// File: rtl/scan_seq_2to4_rr_next_sel.sv
// Round-robin next-channel search (purely combinational).
// Ports:
//   i_cur   : current channel; search starts at (i_cur+1) mod NCH and
//             includes i_cur itself last
//   i_mask  : channel enables, bit i = 1 means channel i is eligible
//   o_nxt   : first eligible channel found (i_cur when none)
//   o_valid : at least one channel is eligible
//   o_wrap  : the search wrapped around (o_nxt <= i_cur); marks end of a frame
// Driving i_cur with NCH-1 makes the search start at channel 0, which gives
// the lowest enabled channel.
module rr_next_sel
  import scan_seq_2to4_pkg::*;
(
  input  logic [SEL_W-1:0] i_cur,
  input  logic [NCH-1:0]   i_mask,
  output logic [SEL_W-1:0] o_nxt,
  output logic             o_valid,
  output logic             o_wrap
);

  logic [SEL_W-1:0] w_idx;
  logic [SEL_W-1:0] w_nxt;

  // Walk candidates from farthest to nearest so the nearest eligible one wins.
  always_comb begin
    w_nxt = i_cur;
    w_idx = i_cur;
    for (int k = NCH; k >= 1; k--) begin
      w_idx = i_cur + SEL_W'(k);
      w_nxt = i_mask[w_idx] ? w_idx : w_nxt;
    end
  end

  assign o_nxt   = w_nxt;
  assign o_valid = |i_mask;
  assign o_wrap  = o_valid && (w_nxt <= i_cur);

endmodule

// File: rtl/scan_seq_2to4.sv
// Scan sequencer feeding a 2-to-4 decoder.
// Round-robin over the enabled channels: each channel gets BLANK_CYC cycles
// with the enable low (select settles) followed by div+1 cycles with the
// enable high. frame_done pulses on the edge where the scan wraps.
// Ports:
//   i_clk          : system clock, rising edge
//   i_rst          : asynchronous active-high reset
//   i_run          : level; 1 = scan, 0 = stop (return to idle next edge)
//   i_div          : dwell length minus 1, latched when a dwell starts
//   i_mask         : channel enables, sampled when a channel ends / at start
//   o_a            : registered decoder select
//   o_en           : registered decoder enable
//   o_frame_done   : registered one-cycle end-of-frame pulse
// BLANK_CYC must lie in 1..255 (8-bit blank counter).
module scan_seq_2to4
  import scan_seq_2to4_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  input  logic [NCH-1:0]   i_mask,
  output logic [SEL_W-1:0] o_a,
  output logic             o_en,
  output logic             o_frame_done
);

  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);

  state_t           r_state;
  logic [SEL_W-1:0] r_a;
  logic             r_en;
  logic             r_frame_done;
  logic [7:0]       r_blank_cnt;
  logic [DIV_W-1:0] r_dwell_cnt;

  state_t           w_state_nxt;
  logic [SEL_W-1:0] w_a_nxt;
  logic             w_en_nxt;
  logic             w_frame_done_nxt;
  logic [7:0]       w_blank_cnt_nxt;
  logic [DIV_W-1:0] w_dwell_cnt_nxt;

  logic [SEL_W-1:0] w_search_cur;
  logic [SEL_W-1:0] w_sel_nxt;
  logic             w_sel_valid;
  logic             w_sel_wrap;

  // From a dwell, search after the current channel; otherwise start from channel 0.
  assign w_search_cur = (r_state == ST_DWELL) ? r_a : SEL_W'(NCH - 1);

  rr_next_sel u_rr_next_sel (
    .i_cur   (w_search_cur),
    .i_mask  (i_mask),
    .o_nxt   (w_sel_nxt),
    .o_valid (w_sel_valid),
    .o_wrap  (w_sel_wrap)
  );

  // State, counter and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_a          <= '0;
      r_en         <= 1'b0;
      r_frame_done <= 1'b0;
      r_blank_cnt  <= 8'd0;
      r_dwell_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_a          <= w_a_nxt;
      r_en         <= w_en_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_blank_cnt  <= w_blank_cnt_nxt;
      r_dwell_cnt  <= w_dwell_cnt_nxt;
    end
  end

  // Next-state and next-output logic; en and frame_done default low.
  always_comb begin
    w_state_nxt      = r_state;
    w_a_nxt          = r_a;
    w_en_nxt         = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_blank_cnt_nxt  = r_blank_cnt;
    w_dwell_cnt_nxt  = r_dwell_cnt;

    if (!i_run) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel_valid) begin
            w_a_nxt         = w_sel_nxt;
            w_state_nxt     = ST_BLANK;
            w_blank_cnt_nxt = 8'd0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end

        ST_BLANK: begin
          if (r_blank_cnt == BLANK_LAST) begin
            // div is captured once here so mid-dwell changes cannot stretch it.
            w_dwell_cnt_nxt = i_div;
            w_state_nxt     = ST_DWELL;
            w_en_nxt        = 1'b1;
          end else begin
            w_blank_cnt_nxt = r_blank_cnt + 8'd1;
          end
        end

        ST_DWELL: begin
          if (r_dwell_cnt == '0) begin
            if (w_sel_valid) begin
              w_a_nxt          = w_sel_nxt;
              w_state_nxt      = ST_BLANK;
              w_blank_cnt_nxt  = 8'd0;
              w_frame_done_nxt = w_sel_wrap;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_en_nxt        = 1'b1;
            w_dwell_cnt_nxt = r_dwell_cnt - DIV_W'(1);
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign o_a          = r_a;
  assign o_en         = r_en;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_scan_seq_2to4.sv
module tb_scan_seq_2to4;

  localparam int DIV_W = 16;
  localparam int BLANK = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             run = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [3:0]       mask = 4'd0;
  logic [1:0]       a;
  logic             en;
  logic             fd;

  always #5 clk = ~clk;

  scan_seq_2to4 #(.DIV_W(DIV_W), .BLANK_CYC(BLANK)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_run        (run),
    .i_div        (div),
    .i_mask       (mask),
    .o_a          (a),
    .o_en         (en),
    .o_frame_done (fd)
  );

  typedef struct packed {
    logic [1:0] a;
    logic       en;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: a scan is "active" on some channel; pos counts cycles
  // since that channel's blanking started (first BLANK cycles en low, then
  // dlen cycles en high).
  bit m_active = 0;
  int m_a      = 0;
  int m_pos    = 0;
  int m_dlen   = 1;
  bit m_en     = 0;
  bit m_fd     = 0;

  function automatic int next_ch(int cur, int mk);
    for (int k = 1; k <= 4; k++) begin
      if (mk[(cur + k) % 4]) return (cur + k) % 4;
    end
    return cur;
  endfunction

  function automatic void model_reset();
    m_active = 0; m_a = 0; m_pos = 0; m_dlen = 1; m_en = 0; m_fd = 0;
  endfunction

  // One rising edge of the model with the inputs sampled at that edge.
  function automatic void model_step(bit r, int d, int mk);
    int nx;
    m_fd = 0;
    if (!r) begin
      m_active = 0;
      m_en     = 0;
    end else if (!m_active) begin
      if (mk != 0) begin
        m_active = 1;
        m_a      = next_ch(3, mk);
        m_pos    = 0;
        m_en     = 0;
      end
    end else if (m_pos < BLANK) begin
      if (m_pos == BLANK - 1) begin
        m_dlen = d + 1;
        m_en   = 1;
      end
      m_pos++;
    end else if (m_pos == BLANK + m_dlen - 1) begin
      m_en = 0;
      if (mk == 0) begin
        m_active = 0;
      end else begin
        nx    = next_ch(m_a, mk);
        m_fd  = (nx <= m_a);
        m_a   = nx;
        m_pos = 0;
      end
    end else begin
      m_pos++;
    end
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of stimulus and queue the response expected after the edge.
  task automatic cycle(bit r, int d, int mk);
    exp_t e;
    @(negedge clk);
    rst  = 1'b0;
    run  = r;
    div  = d[DIV_W-1:0];
    mask = mk[3:0];
    model_step(r, d, mk);
    e.a  = m_a[1:0];
    e.en = m_en;
    e.fd = m_fd;
    sb.push_back(e);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_a", a, 0);
    chk("rst_en", en, 0);
    chk("rst_frame_done", fd, 0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compares every post-edge output against the scoreboard.
  logic [1:0] prev_a = 2'd0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("a", a, e.a);
        chk("en", en, e.en);
        chk("frame_done", fd, e.fd);
        if (en) chk("en_while_a_changes", a, prev_a);
      end
      prev_a = a;
    end
  end

  initial begin
    int cur_mask;
    int cur_div;
    bit r;

    #2 rst = 1'b1;
    #1;
    chk("init_a", a, 0);
    chk("init_en", en, 0);
    chk("init_frame_done", fd, 0);
    model_reset();
    repeat (2) @(negedge clk);

    // Full mask, dwell 4 cycles.
    for (int i = 0; i < 30; i++) cycle(1, 3, 4'hF);

    // Alternating channels 1,3 with single-cycle dwell.
    cycle(0, 0, 4'b1010);
    for (int i = 0; i < 14; i++) cycle(1, 0, 4'b1010);

    // Single channel: en pattern 0,0,1 with frame_done every period.
    cycle(0, 0, 4'b0100);
    for (int i = 0; i < 12; i++) cycle(1, 0, 4'b0100);

    // Drop run in the second dwell cycle, then restart.
    cycle(0, 3, 4'hF);
    for (int i = 0; i < 40 && !(m_active && m_pos == BLANK + 1); i++) cycle(1, 3, 4'hF);
    cycle(0, 3, 4'hF);
    cycle(0, 3, 4'hF);
    for (int i = 0; i < 10; i++) cycle(1, 3, 4'b0110);

    // Mask shrinks during channel 1's dwell, then goes empty.
    cycle(0, 5, 4'hF);
    for (int i = 0; i < 40 && !(m_a == 1 && m_en); i++) cycle(1, 5, 4'hF);
    for (int i = 0; i < 40 && !(m_a == 0 && m_en); i++) cycle(1, 5, 4'b0001);
    for (int i = 0; i < 40 && m_active; i++) cycle(1, 5, 4'b0000);
    for (int i = 0; i < 4; i++) cycle(1, 5, 4'b0000);

    // Reset in the middle of a dwell, then resume from the lowest mask bit.
    for (int i = 0; i < 40 && !(m_en && m_pos > BLANK); i++) cycle(1, 3, 4'hF);
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1, 2, 4'b1100);

    // Randomised operation.
    cur_mask = 4'hF;
    cur_div  = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) cur_mask = int'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) cur_div = int'($urandom_range(0, 4));
      r = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle(r, cur_div, cur_mask);
    end

    @(posedge clk);
    #4;
    chk("queue_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
